// File: rtl/sound_pkg.sv
// Shared types and constants for the melody sequencer: melody ids (which double
// as priority), sequencer states, oscillator note divisors and the ROM entry layout.
package sound_pkg;

    typedef enum logic [1:0] {
        MEL_EAT   = 2'd0,
        MEL_WIN   = 2'd1,
        MEL_CRASH = 2'd2
    } melody_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    localparam logic [7:0] NOTE_REST = 8'd0;
    localparam logic [7:0] NOTE_C4   = 8'd149;
    localparam logic [7:0] NOTE_DS4  = 8'd126;
    localparam logic [7:0] NOTE_E4   = 8'd118;
    localparam logic [7:0] NOTE_G4   = 8'd100;
    localparam logic [7:0] NOTE_A4   = 8'd89;
    localparam logic [7:0] NOTE_C5   = 8'd75;
    localparam logic [7:0] NOTE_E5   = 8'd59;

    // beats == 0 encodes 8 beats.
    typedef struct packed {
        logic [7:0] note;
        logic [2:0] beats;
        logic       last;
    } rom_entry_t;

endpackage

// File: rtl/sound_rom.sv
// Melody table: address {melody, step} to {note, beats, last}. Purely combinational.
module sound_rom
    import sound_pkg::*;
(
    input  logic [3:0]  addr,
    output logic [11:0] entry
);

    rom_entry_t e;

    always_comb begin
        case (addr)
            4'd0:    e = '{NOTE_C5,   3'd1, 1'b0};
            4'd1:    e = '{NOTE_E5,   3'd2, 1'b1};
            4'd4:    e = '{NOTE_C4,   3'd1, 1'b0};
            4'd5:    e = '{NOTE_E4,   3'd1, 1'b0};
            4'd6:    e = '{NOTE_G4,   3'd1, 1'b0};
            4'd7:    e = '{NOTE_C5,   3'd4, 1'b1};
            4'd8:    e = '{NOTE_DS4,  3'd2, 1'b0};
            4'd9:    e = '{NOTE_C4,   3'd2, 1'b0};
            4'd10:   e = '{NOTE_REST, 3'd1, 1'b0};
            4'd11:   e = '{NOTE_C4,   3'd4, 1'b1};
            default: e = '{NOTE_REST, 3'd1, 1'b1};
        endcase
    end

    assign entry = e;

endmodule

// File: rtl/sound_sequencer.sv
// Turns game event edges into timed note sequences for the sound oscillator,
// with priority preemption (crash > win > eat) and a silent gap between notes.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 625000,
    parameter int GAP_TICKS      = 50000
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       ev_eat,
    input  logic       ev_crash,
    input  logic       ev_win,
    input  logic       mute,
    output logic [7:0] freq,
    output logic       playSound,
    output logic       busy,
    output logic       done
);

    localparam int TICK_W = $clog2(TICKS_PER_BEAT + 1);
    localparam int GAP_W  = $clog2(GAP_TICKS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);

    seq_state_t        state_q, state_d;
    melody_t           mel_q, mel_d;
    logic [1:0]        step_q, step_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        beat_q, beat_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              done_q, done_d;
    logic [2:0]        prev_q, prev_d;

    logic [2:0]  trig;
    logic        any_trig;
    melody_t     trig_mel;
    logic        accept;
    logic [11:0] rom_data;
    rom_entry_t  cur;
    logic [2:0]  beats_last;

    sound_rom u_rom (
        .addr  ({mel_q, step_q}),
        .entry (rom_data)
    );

    assign cur        = rom_entry_t'(rom_data);
    // Wraps 0 -> 7, so an encoded beat count of 0 plays 8 beats.
    assign beats_last = cur.beats - 3'd1;

    // Bit order {crash, win, eat}; an input held high through reset triggers once.
    assign prev_d   = {ev_crash, ev_win, ev_eat};
    assign trig     = prev_d & ~prev_q;
    assign any_trig = |trig;

    always_comb begin
        if (trig[2])      trig_mel = MEL_CRASH;
        else if (trig[1]) trig_mel = MEL_WIN;
        else              trig_mel = MEL_EAT;
    end

    assign accept = any_trig && ((state_q == IDLE) || (trig_mel > mel_q));

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q <= IDLE;
            mel_q   <= MEL_EAT;
            step_q  <= '0;
            tick_q  <= '0;
            beat_q  <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            prev_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            mel_q   <= mel_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            prev_q  <= prev_d;
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first; any path that skips an assignment would infer a latch.
        state_d = state_q;
        mel_d   = mel_q;
        step_d  = step_q;
        tick_d  = tick_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        done_d  = 1'b0;

        if (accept) begin
            state_d = PLAY;
            mel_d   = trig_mel;
            step_d  = '0;
            tick_d  = '0;
            beat_d  = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (beat_q == beats_last) begin
                            beat_d = '0;
                            if (cur.last) begin
                                state_d = IDLE;
                                step_d  = '0;
                                done_d  = 1'b1;
                            end else begin
                                state_d = GAP;
                                gap_d   = '0;
                            end
                        end else begin
                            beat_d = beat_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        state_d = PLAY;
                        step_d  = step_q + 2'd1;
                        tick_d  = '0;
                        beat_d  = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        freq      = busy ? cur.note : NOTE_REST;
        playSound = (state_q == PLAY) && (cur.note != NOTE_REST) && !mute;
        done      = done_q;
    end

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Melody sequencer that sits directly upstream of the sound oscillator. It turns single-event game triggers (apple eaten, crash, win) into a timed series of notes. It drives the oscillator's 8-bit `freq` divisor and `playSound` enable, holding each note for an exact number of beats with a short silent gap between notes. Higher-priority events preempt a melody that is already playing.

## Interface
- `TICKS_PER_BEAT`, default 625000: clock cycles per beat (62.5 ms at 10 MHz).
- `GAP_TICKS`, default 50000: silent cycles inserted after each note except the last.
- `clk`  in  1: system clock, 10 MHz.
- `nRst`  in  1: reset, synchronous, active-low.
- `ev_eat`  in  1: apple-eaten event, level; rising edge triggers.
- `ev_crash`  in  1: crash/game-over event, rising edge triggers.
- `ev_win`  in  1: win event, rising edge triggers.
- `mute`  in  1: forces `playSound` low; sequencing continues.
- `freq`  out  8: oscillator divisor; 0 means rest.
- `playSound`  out  1: oscillator enable.
- `busy`  out  1: a melody is in progress.
- `done`  out  1: one-cycle pulse when a melody completes naturally.

## Operation
- Edge detect: `prev_x` registers for each event input, reset to 0. A trigger is `x & ~prev_x`. An input held high through reset release therefore triggers once.
- Priority: crash (2) > win (1) > eat (0).
  - Simultaneous triggers: the highest wins.
  - Trigger while busy: a strictly higher priority restarts at step 0 of the new melody, and no `done` pulse is issued.
  - Trigger of equal or lower priority while busy is ignored and not queued.
- ROM entry: {note[7:0], beats[2:0], last}. Address = {melody[1:0], step[1:0]}, so each melody has at most 4 steps. `beats` = 0 means 8.
- Melodies (divisor/beats):
  - EAT: 75/1, 59/2.
  - CRASH: 126/2, 149/2, 0/1, 149/4.
  - WIN: 149/1, 118/1, 100/1, 75/4.
- Note codes: 149 = C4, 126 = D#4, 118 = E4, 100 = G4, 89 = A4, 75 = C5, 59 = E5. A note code of 0 is a rest: `playSound` = 0 and `freq` = 0 for that step.
- FSM states:
  - IDLE → PLAY on any accepted trigger.
  - PLAY → GAP when the note's cycle count expires and `last` = 0.
  - PLAY → IDLE when the count expires and `last` = 1; `done` is raised.
  - GAP → PLAY (step+1) after `GAP_TICKS` cycles.
  - PLAY/GAP → PLAY (step 0, new melody) on preemption.
- Outputs by state:
  - `playSound` = (state == PLAY) & (note != 0) & ~`mute`.
  - `freq` holds the current note through PLAY and GAP, and returns to 0 in IDLE.
  - `busy` = (state != IDLE).
- Counters:
  - Beat-tick counter, 0..`TICKS_PER_BEAT`-1, and beat counter, 3 bits. Both clear on every note start; neither is free-running.
  - Gap counter, ceil(log2(`GAP_TICKS`+1)) bits.
  - No counter wraps unintentionally; every compare is against terminal value minus 1.

## Timing
- Reset, synchronous: state IDLE, `freq` = 0, `playSound` = 0, `busy` = 0, `done` = 0, all counters and `prev_*` = 0. Reset asserted mid-melody silences the outputs at the next edge.
- Latency: event high in cycle N (with `prev` low) → `freq`/`playSound`/`busy` valid in cycle N+1.
- A note lasts exactly beats × `TICKS_PER_BEAT` cycles with `playSound` high.
- A gap lasts exactly `GAP_TICKS` cycles with `playSound` low and `freq` unchanged.
- `done` is high for exactly the first IDLE cycle after the last note; `busy` is low in that same cycle.
- A new trigger in the `done` cycle is accepted normally.
- Preemption: the new melody's first note appears in the cycle after the trigger edge, and its counters restart.
- `mute` is combinational onto `playSound` with no state effect; `freq` and timing are unchanged.

## Structure
- `sound_pkg` holds:
  - the `melody_t` enum (MEL_EAT = 0, MEL_WIN = 1, MEL_CRASH = 2), whose value doubles as priority;
  - the `seq_state_t` enum (IDLE, PLAY, GAP);
  - the note constants NOTE_C4 … NOTE_E5 and NOTE_REST = 0.
- Sub-module `sound_rom`: combinational, 4-bit address to 12-bit entry. Unused addresses return {0, 1, last = 1}.
- Top level contains the edge detect, priority encoder, FSM and counters.

## Test plan
Bench parameters: `TICKS_PER_BEAT` = 4, `GAP_TICKS` = 2.
- Reset with all events low → `freq` = 0, `playSound` = 0, `busy` = 0, `done` = 0; these hold for 3 cycles after release.
- `ev_eat` pulse in cycle N:
  - `freq` = 75 with `playSound` = 1 for cycles N+1..N+4;
  - `playSound` = 0 with `freq` = 75 for N+5..N+6;
  - `freq` = 59 with `playSound` = 1 for N+7..N+14;
  - N+15: `done` = 1, `busy` = 0, `freq` = 0.
- `ev_crash` 3 cycles into EAT → next cycle `freq` = 126, `playSound` = 1; CRASH plays to completion; exactly one `done`.
- `ev_eat` pulse during CRASH → ignored; CRASH step timing unchanged. `ev_eat` and `ev_win` in the same cycle → WIN plays (`freq` 149, 118, 100, 75).
- CRASH with `mute` = 1 → `playSound` never high; `freq` sequence 126, 149, 0, 149 with identical timing; `done` still pulses. The rest step shows `freq` = 0 even when unmuted.
- `nRst` low mid-WIN → next cycle all outputs 0. `ev_win` held high across reset release → WIN restarts exactly once.
